// File: rtl/cacheline_burst_adaptor_if.sv
// Bundle of the cache-side and memory-side signals of the line/burst adaptor.
// The slave modport is the adaptor's view; the master modport is the view of
// whatever drives it (the LLC together with the memory model).
interface cacheline_burst_adaptor_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
);
    // cache side
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic [ADDR_WIDTH-1:0]  address_i;
    logic                   read_i;
    logic                   write_i;
    logic                   resp_o;
    // memory side
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [ADDR_WIDTH-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Bridges a one-line-per-request cache port to a beat-per-ack burst memory
// port. The request is latched at accept; a beat counter walks the line
// slices, and a single-cycle resp_o closes each transaction.
module cacheline_burst_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    cacheline_burst_adaptor_if.slave bus
);
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    // A line that is not a whole number of beats cannot be sliced.
    generate
        if ((LINE_WIDTH % BURST_WIDTH) != 0 || BEATS < 1) begin : g_bad_ratio
            $error("LINE_WIDTH must be a non-zero integer multiple of BURST_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        beat_cnt_reg, beat_cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [LINE_WIDTH-1:0]   wline_reg, wline_next;
    logic [LINE_WIDTH-1:0]   line_reg, line_next;

    // Each read slice captures burst_i only on the ack that addresses it.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_rd_slice
            assign line_next[gi*BURST_WIDTH +: BURST_WIDTH] =
                (state_reg == READ && bus.resp_i && beat_cnt_reg == CNT_W'(gi))
                    ? bus.burst_i
                    : line_reg[gi*BURST_WIDTH +: BURST_WIDTH];
        end
    endgenerate

    // Next-state logic: accept (read before write), count acks, one DONE cycle.
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        addr_next     = addr_reg;
        wline_next    = wline_reg;
        case (state_reg)
            IDLE: begin
                if (bus.read_i) begin
                    addr_next  = bus.address_i & ADDR_MASK;
                    state_next = READ;
                end else if (bus.write_i) begin
                    addr_next  = bus.address_i & ADDR_MASK;
                    wline_next = bus.line_i;
                    state_next = WRITE;
                end
            end
            READ, WRITE: begin
                if (bus.resp_i) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        state_next    = DONE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            addr_reg     <= '0;
            wline_reg    <= '0;
            line_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            addr_reg     <= addr_next;
            wline_reg    <= wline_next;
            line_reg     <= line_next;
        end
    end

    // Memory-side controls decode from state only, never from the LLC request.
    assign bus.read_o    = (state_reg == READ);
    assign bus.write_o   = (state_reg == WRITE);
    assign bus.resp_o    = (state_reg == DONE);
    assign bus.address_o = addr_reg;
    assign bus.line_o    = line_reg;
    assign bus.burst_o   = wline_reg[beat_cnt_reg*BURST_WIDTH +: BURST_WIDTH];
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: stimulus pushes expected transactions/beats, a negedge
// monitor pops and compares them whenever the adaptor acks or completes.
module tb_cacheline_burst_adaptor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cacheline_burst_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) bus ();
    cacheline_burst_adaptor_if #(.LINE_WIDTH(64),  .BURST_WIDTH(64), .ADDR_WIDTH(32)) bus1 ();

    cacheline_burst_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cacheline_burst_adaptor #(.LINE_WIDTH(64), .BURST_WIDTH(64), .ADDR_WIDTH(32)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        bit            rd;
        logic [31:0]   addr;
        logic [255:0]  line;
    } txn_t;

    txn_t        exp_q[$];
    logic [63:0] beat_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: write beats on each ack, whole transaction on resp_o.
    int ack_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            ack_cnt = 0;
        end else begin
            if (bus.resp_i && (bus.read_o || bus.write_o)) ack_cnt++;
            if (bus.write_o && bus.resp_i) begin
                if (beat_q.size() == 0) chk("unexpected_wbeat", 256'(bus.burst_o), 256'hx);
                else chk("burst_o", 256'(bus.burst_o), 256'(beat_q.pop_front()));
            end
            if (bus.resp_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 256'(bus.resp_o), 256'd0);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("address_o", 256'(bus.address_o), 256'(t.addr));
                    chk("read_o_in_done", 256'(bus.read_o), 256'd0);
                    chk("write_o_in_done", 256'(bus.write_o), 256'd0);
                    chk("acks_per_txn", 256'(ack_cnt), 256'd4);
                    if (t.rd) chk("line_o", bus.line_o, t.line);
                end
                ack_cnt = 0;
            end
        end
    end

    // Drive the ack pattern (LSB first) starting just after the accept edge,
    // then wait for resp_o and release the request one edge later.
    task automatic serve(input int n, input logic [15:0] pat, input logic [255:0] rdata);
        int k = 0;
        int t = 0;
        for (int i = 0; i < n; i++) begin
            bus.resp_i  = pat[i];
            bus.burst_i = (k < 4) ? rdata[k*64 +: 64] : 64'h0;
            if (pat[i]) k++;
            @(posedge clk); #1;
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = 64'h0;
        while (!bus.resp_o && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) chk("resp_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    localparam logic [255:0] WLINE = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    localparam logic [255:0] RD1   = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    localparam logic [255:0] RD2   = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                                      64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};

    initial begin
        txn_t t;
        bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
        bus.burst_i = '0; bus.resp_i = 0;
        bus1.line_i = '0; bus1.address_i = '0; bus1.read_i = 0; bus1.write_i = 0;
        bus1.burst_i = '0; bus1.resp_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_read_o",    256'(bus.read_o),    256'd0);
        chk("rst_write_o",   256'(bus.write_o),   256'd0);
        chk("rst_resp_o",    256'(bus.resp_o),    256'd0);
        chk("rst_address_o", 256'(bus.address_o), 256'd0);
        chk("rst_burst_o",   256'(bus.burst_o),   256'd0);
        chk("rst_line_o",    bus.line_o,          256'd0);
        $display("txn reset: outputs checked");

        // Read 0x1234, four back-to-back beats A0..A3
        t.rd = 1; t.addr = 32'h0000_1220; t.line = RD1; exp_q.push_back(t);
        bus.address_i = 32'h0000_1234; bus.read_i = 1;
        @(posedge clk); #1;
        bus.address_i = 32'hFFFF_FFFF;
        chk("read_o_active", 256'(bus.read_o), 256'd1);
        serve(4, 16'b1111, RD1);
        bus.read_i = 0;
        $display("txn read addr=0x00001234 contiguous beats");

        // Write with gapped acks 1,0,0,1,1,0,1; line_i changed after accept
        t.rd = 0; t.addr = 32'h0000_8000; t.line = '0; exp_q.push_back(t);
        beat_q.push_back(64'h8796A5B4C3D2E1F0);
        beat_q.push_back(64'h0F1E2D3C4B5A6978);
        beat_q.push_back(64'hFEDCBA9876543210);
        beat_q.push_back(64'h0123456789ABCDEF);
        bus.address_i = 32'h0000_801F; bus.line_i = WLINE; bus.write_i = 1;
        @(posedge clk); #1;
        bus.line_i = '1;
        chk("write_o_active", 256'(bus.write_o), 256'd1);
        serve(7, 16'b1011001, '0);
        bus.write_i = 0;
        $display("txn write addr=0x0000801f gapped acks");

        // Read and write together: read first, write follows its resp_o
        t.rd = 1; t.addr = 32'h0000_ABE0; t.line = RD2; exp_q.push_back(t);
        t.rd = 0; t.addr = 32'h0000_ABE0; t.line = '0; exp_q.push_back(t);
        beat_q.push_back(64'h8796A5B4C3D2E1F0);
        beat_q.push_back(64'h0F1E2D3C4B5A6978);
        beat_q.push_back(64'hFEDCBA9876543210);
        beat_q.push_back(64'h0123456789ABCDEF);
        bus.address_i = 32'h0000_ABFF; bus.line_i = WLINE; bus.read_i = 1; bus.write_i = 1;
        @(posedge clk); #1;
        chk("prio_read_o",  256'(bus.read_o),  256'd1);
        chk("prio_write_o", 256'(bus.write_o), 256'd0);
        serve(8, 16'b10010110, RD2);
        bus.read_i = 0;
        @(posedge clk); #1;
        chk("then_write_o", 256'(bus.write_o), 256'd1);
        serve(4, 16'b1111, '0);
        bus.write_i = 0;
        $display("txn read+write together: read then write");

        // Spurious acks in IDLE leave everything alone
        bus.resp_i = 1; bus.burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        repeat (3) @(posedge clk);
        #1 bus.resp_i = 0;
        chk("idle_line_o", bus.line_o,          RD2);
        chk("idle_read_o", 256'(bus.read_o),    256'd0);
        chk("idle_resp_o", 256'(bus.resp_o),    256'd0);
        $display("txn spurious resp_i in idle");

        // Reset at beat 2 of a read aborts it
        bus.address_i = 32'h0000_0040; bus.read_i = 1;
        @(posedge clk); #1;
        bus.resp_i = 1; bus.burst_i = 64'h55;
        @(posedge clk); #1;
        bus.burst_i = 64'h66;
        @(posedge clk); #1;
        rst = 1; bus.resp_i = 0; bus.read_i = 0;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_read_o", 256'(bus.read_o), 256'd0);
        chk("abort_line_o", bus.line_o,       256'd0);
        chk("abort_resp_o", 256'(bus.resp_o), 256'd0);
        $display("txn reset mid-read");

        // Read after reset completes normally
        t.rd = 1; t.addr = 32'h0000_1220; t.line = RD1; exp_q.push_back(t);
        bus.address_i = 32'h0000_1234; bus.read_i = 1;
        @(posedge clk); #1;
        serve(5, 16'b11101, RD1);
        bus.read_i = 0;
        $display("txn read after reset");

        // Single-beat line: one ack, DONE on the very next cycle
        bus1.address_i = 32'h1234_5677; bus1.read_i = 1;
        @(posedge clk); #1;
        bus1.resp_i = 1; bus1.burst_i = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk); #1;
        bus1.resp_i = 0;
        chk("b1_resp_o",    256'(bus1.resp_o),    256'd1);
        chk("b1_address_o", 256'(bus1.address_o), 256'h1234_5670);
        chk("b1_line_o",    256'(bus1.line_o),    256'hDEAD_BEEF_CAFE_F00D);
        @(posedge clk); #1;
        bus1.read_i = 0;
        chk("b1_resp_pulse", 256'(bus1.resp_o), 256'd0);
        $display("txn single-beat read addr=0x12345677");

        repeat (4) @(posedge clk);
        #1;
        chk("txn_queue_drained",  256'(exp_q.size()),  256'd0);
        chk("beat_queue_drained", 256'(beat_q.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
